// File: rtl/snes_input_arbiter_if.sv
// Bus between the controller sources and the arbiter.
// The master modport drives the sources and the select inputs.
// The slave modport returns the button word and status to the SNES side.
interface snes_input_arbiter_if #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SEL_W   = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC)
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     auto_mode;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         active_src;
    logic                     switching;

    modport master (
        output src_data, sel, auto_mode,
        input  out_data, active_src, switching
    );

    modport slave (
        input  src_data, sel, auto_mode,
        output out_data, active_src, switching
    );
endinterface

// File: rtl/snes_input_arbiter.sv
// Selects one of several controller sources and passes it on to the SNES serializer.
// Selection is either manual (DIP-switch select) or automatic (by activity).
// Every source switch forces an all-released gap, so the console never sees
// buttons from two pads spliced together.
module snes_input_arbiter #(
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    snes_input_arbiter_if.slave  bus
);
    localparam int unsigned SEL_W  = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    typedef enum logic {StPass, StGap} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               started_q, started_d;

    logic [WIDTH-1:0]   cur_slice;
    logic [WIDTH-1:0]   next_slice;
    logic               auto_hit;
    logic [SEL_W-1:0]   auto_tgt;
    logic               want_switch;
    logic [SEL_W-1:0]   tgt;

    // Current active slice and the lowest-indexed other source with any button pressed
    always_comb begin
        cur_slice = '0;
        auto_hit  = 1'b0;
        auto_tgt  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_q == SEL_W'(i)) begin
                cur_slice = bus.src_data[i*WIDTH +: WIDTH];
            end
            if (!auto_hit && (active_q != SEL_W'(i)) && (|bus.src_data[i*WIDTH +: WIDTH])) begin
                auto_hit = 1'b1;
                auto_tgt = SEL_W'(i);
            end
        end
    end

    // Switch request from whichever selection rule is in force this cycle
    always_comb begin
        want_switch = 1'b0;
        tgt         = active_q;
        if (!bus.auto_mode) begin
            // Out-of-range DIP settings are ignored; the current source is kept
            if ((32'(bus.sel) < NUM_SRC) && (bus.sel != active_q)) begin
                want_switch = 1'b1;
                tgt         = bus.sel;
            end
        end else if ((state_q == StPass) && (idle_q == IDLE_W'(IDLE_CYCLES)) && auto_hit) begin
            want_switch = 1'b1;
            tgt         = auto_tgt;
        end
    end

    // FSM next state, gap/idle counters and target update
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        gap_d     = gap_q;
        started_d = 1'b1;
        if (cur_slice == '0) begin
            idle_d = (idle_q == IDLE_W'(IDLE_CYCLES)) ? idle_q : idle_q + IDLE_W'(1);
        end else begin
            idle_d = '0;
        end

        if (!started_q) begin
            // First edge after reset just passes source 0 through
            state_d = StPass;
        end else if (want_switch) begin
            // Covers both a fresh switch and a retarget that restarts the gap
            state_d  = StGap;
            active_d = tgt;
            gap_d    = GAP_W'(GAP_CYCLES);
            idle_d   = '0;
        end else if (state_q == StGap) begin
            gap_d  = gap_q - GAP_W'(1);
            idle_d = '0;
            if (gap_q == GAP_W'(1)) begin
                state_d = StPass;
            end
        end
    end

    // Slice of the source that will be active after this edge
    always_comb begin
        next_slice = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_d == SEL_W'(i)) begin
                next_slice = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
        out_d = (state_d == StPass) ? next_slice : '0;
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StPass;
            active_q  <= '0;
            gap_q     <= '0;
            idle_q    <= '0;
            out_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            gap_q     <= gap_d;
            idle_q    <= idle_d;
            out_q     <= out_d;
            started_q <= started_d;
        end
    end

    assign bus.out_data   = out_q;
    assign bus.active_src = active_q;
    assign bus.switching  = (state_q == StGap);
endmodule

// File: tb/tb_snes_input_arbiter.sv
// Self-checking bench for snes_input_arbiter: a default 3x8 instance and an 8x12 instance.
module tb_snes_input_arbiter;
    logic clk;
    logic reset;

    snes_input_arbiter_if #(.NUM_SRC(3), .WIDTH(8))  bus_a ();
    snes_input_arbiter_if #(.NUM_SRC(8), .WIDTH(12)) bus_b ();

    snes_input_arbiter #(
        .NUM_SRC(3), .WIDTH(8), .GAP_CYCLES(4), .IDLE_CYCLES(16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    snes_input_arbiter #(
        .NUM_SRC(8), .WIDTH(12), .GAP_CYCLES(4), .IDLE_CYCLES(16)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        bit          use_b;
        logic [15:0] out;
        logic [3:0]  src;
        logic        sw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue the expectation for the coming edge, advance, then score it
    task automatic step(input bit use_b, input logic [15:0] out, input logic [3:0] src,
                        input logic sw);
        exp_t e;
        e.use_b = use_b;
        e.out   = out;
        e.src   = src;
        e.sw    = sw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.use_b) begin
            check("b_out_data",   32'(bus_b.out_data),   32'(e.out));
            check("b_active_src", 32'(bus_b.active_src), 32'(e.src));
            check("b_switching",  32'(bus_b.switching),  32'(e.sw));
        end else begin
            check("a_out_data",   32'(bus_a.out_data),   32'(e.out));
            check("a_active_src", 32'(bus_a.active_src), 32'(e.src));
            check("a_switching",  32'(bus_a.switching),  32'(e.sw));
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus_a.src_data  = {8'h00, 8'h3C, 8'h81};
        bus_a.sel       = 2'd0;
        bus_a.auto_mode = 1'b0;
        bus_b.src_data  = '0;
        bus_b.sel       = 3'd0;
        bus_b.auto_mode = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out", 32'(bus_a.out_data),   32'h0);
        check("rst_a_src", 32'(bus_a.active_src), 32'h0);
        check("rst_a_sw",  32'(bus_a.switching),  32'h0);
        check("rst_b_out", 32'(bus_b.out_data),   32'h0);
        reset = 1'b0;

        // Manual switch 0 -> 1 with a 4-cycle gap
        step(0, 16'h81, 4'd0, 1'b0);
        step(0, 16'h81, 4'd0, 1'b0);
        bus_a.sel = 2'd1;
        repeat (4) step(0, 16'h00, 4'd1, 1'b1);
        step(0, 16'h3C, 4'd1, 1'b0);
        step(0, 16'h3C, 4'd1, 1'b0);
        bus_a.src_data[15:8] = 8'hC3;
        step(0, 16'hC3, 4'd1, 1'b0);

        // Retarget two cycles into the gap: 2 + 4 gap cycles, ends on source 2
        bus_a.src_data[23:16] = 8'h5A;
        bus_a.sel = 2'd0;
        repeat (2) step(0, 16'h00, 4'd0, 1'b1);
        bus_a.sel = 2'd2;
        repeat (4) step(0, 16'h00, 4'd2, 1'b1);
        step(0, 16'h5A, 4'd2, 1'b0);

        // Illegal select is ignored
        bus_a.sel = 2'd3;
        step(0, 16'h5A, 4'd2, 1'b0);
        bus_a.src_data[23:16] = 8'hA5;
        step(0, 16'hA5, 4'd2, 1'b0);
        step(0, 16'hA5, 4'd2, 1'b0);

        // Asynchronous reset in the middle of a gap
        bus_a.sel = 2'd0;
        repeat (2) step(0, 16'h00, 4'd0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", 32'(bus_a.out_data),   32'h0);
        check("async_rst_src", 32'(bus_a.active_src), 32'h0);
        check("async_rst_sw",  32'(bus_a.switching),  32'h0);
        bus_a.sel = 2'd1;
        @(posedge clk);
        #1;
        check("held_rst_sw", 32'(bus_a.switching), 32'h0);
        reset = 1'b0;
        // First edge passes source 0 even though sel points elsewhere
        step(0, 16'h81, 4'd0, 1'b0);
        repeat (4) step(0, 16'h00, 4'd1, 1'b1);
        step(0, 16'hC3, 4'd1, 1'b0);

        // Auto mode: idle source 0, activity on 1 and 2, sel must be ignored
        reset = 1'b1;
        bus_a.src_data  = {8'h01, 8'h10, 8'h00};
        bus_a.auto_mode = 1'b1;
        bus_a.sel       = 2'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) step(0, 16'h00, 4'd0, 1'b0);
        bus_a.src_data[7:0] = 8'h02;
        step(0, 16'h02, 4'd0, 1'b0);
        bus_a.src_data[7:0] = 8'h00;
        for (int k = 11; k <= 26; k++) step(0, 16'h00, 4'd0, 1'b0);
        repeat (4) step(0, 16'h00, 4'd1, 1'b1);
        step(0, 16'h10, 4'd1, 1'b0);
        bus_a.src_data[7:0] = 8'h40;
        repeat (3) step(0, 16'h10, 4'd1, 1'b0);

        // Width sweep on the 8x12 instance: walking one through each source
        for (int s = 1; s <= 8; s++) begin
            int idx;
            idx = s % 8;
            bus_b.src_data = '0;
            bus_b.sel      = 3'(idx);
            repeat (4) step(1, 16'h000, 4'(idx), 1'b1);
            for (int b = 0; b < 12; b++) begin
                logic [11:0] pat;
                pat = 12'(1) << b;
                bus_b.src_data = '0;
                bus_b.src_data[idx*12 +: 12] = pat;
                step(1, 16'(pat), 4'(idx), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/snes_input_arbiter.md
SNES_INPUT_ARBITER -- requirements
Module: snes_input_arbiter

Interface
REQ-001 Parameter NUM_SRC, 3, number of controller sources (keypad, IR, button board, ...); legal range 2..8.
REQ-002 Parameter WIDTH, 8, button bits per source; bit=1 means pressed.
REQ-003 Parameter GAP_CYCLES, 4, all-released cycles inserted on every source switch; legal range 1..255.
REQ-004 Parameter IDLE_CYCLES, 16, consecutive all-zero cycles of the active source before auto mode may switch; legal range 1..65535.
REQ-005 Derived SEL_W = max(1, clog2(NUM_SRC)).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 src_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-009 sel  input  SEL_W  manual source select (the DIP switches).
REQ-010 auto_mode  input  1  0 = manual select by sel, 1 = automatic select by activity.
REQ-011 out_data  output  WIDTH  registered button word to the SNES serializer.
REQ-012 active_src  output  SEL_W  index of the source currently driving out_data (or the switch target while in GAP).
REQ-013 switching  output  1  high for every cycle in GAP state.

Function
REQ-014 FSM states: PASS (out_data follows the active source), GAP (out_data forced to zero).
REQ-015 In PASS, out_data SHALL equal src_data slice of active_src sampled on the previous edge (1-cycle latency).
REQ-016 Manual mode: a legal target is sel when sel < NUM_SRC; sel >= NUM_SRC SHALL be ignored and the current source retained (no latch-up, no X on out_data).
REQ-017 Manual mode: in PASS, if the legal target != active_src, the next edge SHALL enter GAP, load active_src with the target, and load gap counter with GAP_CYCLES.
REQ-018 In GAP, out_data SHALL be 0 and the gap counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL return to PASS, so out_data is zero for exactly GAP_CYCLES cycles.
REQ-019 A new legal target differing from active_src arriving during GAP SHALL retarget active_src and reload the counter to GAP_CYCLES (gap restarts).
REQ-020 Auto mode: idle counter counts consecutive cycles with the active source slice == 0, saturating at IDLE_CYCLES; any non-zero bit clears it.
REQ-021 Auto mode: in PASS, when idle counter == IDLE_CYCLES and any other source is non-zero, the lowest-indexed non-zero other source SHALL become the target and the FSM SHALL enter GAP as in REQ-017.
REQ-022 Auto mode: sel SHALL be ignored; a non-zero active source SHALL never be preempted.
REQ-023 Changing auto_mode SHALL NOT by itself cause a switch; the new mode's rule applies from the next edge; idle counter SHALL be cleared on any switch.
REQ-024 switching SHALL be 1 exactly when state == GAP.

Reset
REQ-025 While reset is high: state = PASS, active_src = 0, out_data = 0, switching = 0, gap and idle counters = 0; asserted asynchronously, including mid-GAP.
REQ-026 First edge after reset deassertion SHALL behave as PASS on source 0 (out_data = source 0 one cycle later), then manual/auto rules apply; if sel != 0 in manual mode a GAP follows.

Verification
REQ-027 Manual, GAP_CYCLES=4: src0=0x81, src1=0x3C, sel 0->1 -> switching high 4 cycles, out_data 0x00 for 4 cycles, then 0x3C, active_src=1.
REQ-028 Manual, NUM_SRC=3: sel=3 while on source 2 -> active_src stays 2, out_data tracks src2, switching never asserts.
REQ-029 Retarget: sel 0->1, then ->2 two cycles into the gap -> gap lasts 2+4 cycles total, ends on source 2.
REQ-030 Auto, IDLE_CYCLES=16: active src0 held 0, src1=0x10 and src2=0x01 -> switch after 16 idle cycles to source 1 (lowest index), gap, then out_data 0x10; src0 pressed at cycle 10 -> no switch.
REQ-031 Reset asserted mid-GAP -> outputs zero immediately (asynchronously), after release out_data follows source 0 with 1-cycle latency.
REQ-032 Width sweep: NUM_SRC=8, WIDTH=12, walking-one per source via manual sel -> each source's bits appear on out_data unaltered after its gap.
